uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Packet-level arbiter that shares the single `UART_tx` serial transmitter between several byte-stream requesters, such as the telemetry frame generator and a fault/diagnostic message source. It grants the UART to one requester per packet, so packets never interleave. It forwards each byte as a `trmt` pulse and paces requesters with a per-byte acknowledge. It sits between the requesters and `UART_tx`, and drives `trmt`/`tx_data` in place of any single source.

## Interface
- `NUM_REQ`, default 2: number of requesters; index 0 has the highest priority after reset.
- `TIMEOUT`, default 1024: idle cycles allowed mid-packet before the grant is revoked; range 2..65535.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  requester i has a byte ready on its data slice.
- `req_data`  in  8*NUM_REQ  byte for requester i on bits [8i+7:8i].
- `req_last`  in  NUM_REQ  the byte presented is the final byte of the packet.
- `req_ack`  out  NUM_REQ  one-cycle pulse: requester i's byte was accepted.
- `grant`  out  NUM_REQ  one-hot; the requester currently owning the UART.
- `abort`  out  1  one-cycle pulse: a packet was terminated by timeout.
- `trmt`  out  1  one-cycle start pulse to `UART_tx`.
- `tx_data`  out  8  byte to `UART_tx`; held until the next `trmt`.
- `tx_done`  in  1  `UART_tx` done flag; set at end of a byte, cleared by `trmt`.

## Operation
- State machine has three states: IDLE, ISSUE, DRAIN.
- An internal `busy` flag is set on every `trmt`.
  - It clears when `tx_done`=1 in any cycle after the `trmt` cycle.
  - Because reset clears `busy`, the first byte issues without waiting for `tx_done`.
- **IDLE**
  - If any `req_valid` is high and `busy`=0, select a winner round-robin, starting at the index after the last completed grant.
  - Register `grant` to the one-hot winner and go to ISSUE.
  - If no request is pending, stay in IDLE with `grant`=0.
- **ISSUE**
  - If `busy`=0 and `req_valid[g]`=1, issue the byte at the next edge: `trmt`=1, `tx_data`=`req_data[g]`, `req_ack[g]`=1, `busy`=1.
  - If that byte had `req_last[g]`=1, go to DRAIN; otherwise stay in ISSUE.
  - Other requesters' `req_valid` values are ignored while a grant is held.
- **Timeout (in ISSUE)**
  - A 16-bit counter increments each cycle with `busy`=0 and `req_valid[g]`=0.
  - The counter resets on every issued byte and on entry to ISSUE.
  - When the counter reaches `TIMEOUT`-1: pulse `abort`, clear `grant`, advance the round-robin pointer past g, and go to IDLE.
- **DRAIN**
  - Wait for `busy`=0, then clear `grant`, advance the round-robin pointer past g, and go to IDLE.
- A single-byte packet is valid: its one byte has `req_last`=1, and ISSUE goes directly to DRAIN.
- **Simultaneous events**
  - Requests arriving together are resolved by round-robin order only.
  - `tx_done` arriving in the same cycle as an issue decision has no effect, because the decision uses registered `busy`.
- **Reset mid-operation:** all state clears immediately; any partially sent UART byte is the UART's concern.

## Timing
- Reset values:
  - `trmt`=0, `tx_data`=0x00, `req_ack`=0, `grant`=0, `abort`=0.
  - State IDLE, `busy`=0, round-robin pointer at index 0, counter 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency from `req_valid` rising in IDLE (UART idle):
  - `grant` goes high at edge +1.
  - `trmt` and `req_ack` go high at edge +2.
- Per byte, the next `trmt` follows no sooner than 1 cycle after `tx_done` rises.
- `req_ack` and `trmt` are always coincident; exactly one `req_ack` bit is high at a time.
- Requesters must hold `req_data` and `req_last` stable while `req_valid` is high until `req_ack`.
  - They may change them in the cycle after `req_ack`.
- Between packets, `grant` is 0 for at least one cycle (the IDLE cycle).

## Structure
- Shared package `ebike_uart_pkg` holds:
  - the `arb_state_t` enum (IDLE, ISSUE, DRAIN);
  - constant `BYTE_W`=8;
  - default `TIMEOUT`.
- The package is also imported by the telemetry and fault-message sources.
- One sub-module, `rr_picker`, is natural: a purely combinational round-robin one-hot select.
  - Inputs: `req` vector and pointer.
  - Output: one-hot winner.
- FSM, `busy` flag, timeout counter and output registers live in `uart_tx_arb`.

## Test plan
- **Single packet:** requester 0 sends 8 bytes 0xAA, 0x55, 0x01–0x06 with the last on 0x06, against a UART model at 5208 cycles per byte.
  - Required: 8 `trmt` pulses carrying those bytes in order.
  - Required: `grant`=01 throughout, then 00.
- **Contention:** both requesters raise `req_valid` at reset release; requester 0 sends 3 bytes (0x11–0x13), requester 1 sends 2 bytes (0xE1, 0xE2).
  - Required: requester 0's bytes first, then requester 1's, never interleaved.
- **Fairness:** both requesters request continuously with 1-byte packets.
  - Required: grants alternate 01, 10, 01, 10…
- **Timeout:** `TIMEOUT`=16; requester 0 sends 0xAA without last, then drops `req_valid`.
  - Required: `abort` pulses 16 idle cycles after `busy` clears.
  - Required: `grant`→00, and a pending requester 1 is granted next.
- **Reset mid-packet:** assert `rst_n`=0 after 2 bytes of a 5-byte packet.
  - Required: all outputs at reset values immediately.
  - Required: the next packet from requester 1 starts cleanly, with its first `trmt` 2 cycles after `req_valid`.
- **Single-byte packet with `tx_done` already high:** send a byte with `req_last`=1.
  - Required: exactly one `trmt`, then DRAIN, then IDLE.
  - Required: no spurious second `trmt`.

Source files
------------

// File: rtl/ebike_uart_pkg.sv
// Shared definitions for the e-bike UART path: arbiter state encoding,
// byte width and the default mid-packet timeout.
package ebike_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int BYTE_W          = 8;
  localparam int TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/uart_tx_arb_rr_picker.sv
// Combinational round-robin select: the first requester at or after ptr
// (wrapping) wins, reported as a one-hot vector.
module rr_picker
  import ebike_uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win
);

  logic [2*NUM_REQ-1:0] req2_s;
  logic [NUM_REQ-1:0]   rot_s;
  logic [NUM_REQ-1:0]   oh_s;

  // Rotate so ptr sits at bit 0, isolate lowest set bit, rotate back.
  always_comb begin
    req2_s = {req, req};
    rot_s  = NUM_REQ'(req2_s >> ptr);
    oh_s   = rot_s & (~rot_s + NUM_REQ'(1));
    win    = NUM_REQ'(({oh_s, oh_s} << ptr) >> NUM_REQ);
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level arbiter sharing one UART transmitter between byte-stream
// requesters; one grant per packet, one trmt/req_ack pulse per byte.
module uart_tx_arb
  import ebike_uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      abort,
  output logic                      trmt,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_done
);

  localparam int          PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  arb_state_t         state_r;
  logic [NUM_REQ-1:0] grant_r;
  logic [PTR_W-1:0]   ptr_r;
  logic [15:0]        cnt_r;
  logic               busy_r;
  logic               trmt_r;
  logic [BYTE_W-1:0]  tx_data_r;
  logic [NUM_REQ-1:0] req_ack_r;
  logic               abort_r;

  logic [NUM_REQ-1:0] win_s;
  logic [BYTE_W-1:0]  sel_data_s;
  logic               sel_last_s;
  logic               sel_valid_s;
  logic [PTR_W-1:0]   gidx_s;
  logic [PTR_W-1:0]   next_ptr_s;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req (req_valid),
    .ptr (ptr_r),
    .win (win_s)
  );

  // Mux the granted requester's byte/last/valid and derive the pointer past it.
  always_comb begin
    sel_data_s = '0;
    sel_last_s = 1'b0;
    gidx_s     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data_s = sel_data_s | ({BYTE_W{grant_r[i]}} & req_data[i*BYTE_W +: BYTE_W]);
      sel_last_s = sel_last_s | (grant_r[i] & req_last[i]);
      gidx_s     = gidx_s | ({PTR_W{grant_r[i]}} & PTR_W'(i));
    end
    sel_valid_s = |(req_valid & grant_r);
    next_ptr_s  = (gidx_s == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_s + PTR_W'(1);
  end

  // Arbiter FSM with busy tracking, idle timeout and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      grant_r   <= '0;
      ptr_r     <= '0;
      cnt_r     <= 16'd0;
      busy_r    <= 1'b0;
      trmt_r    <= 1'b0;
      tx_data_r <= '0;
      req_ack_r <= '0;
      abort_r   <= 1'b0;
    end else begin
      trmt_r    <= 1'b0;
      req_ack_r <= '0;
      abort_r   <= 1'b0;
      // tx_done seen during the trmt cycle is the stale flag of the previous byte.
      if (tx_done && !trmt_r) begin
        busy_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if ((|req_valid) && !busy_r) begin
            grant_r <= win_s;
            cnt_r   <= 16'd0;
            state_r <= ISSUE;
          end
        end
        ISSUE: begin
          if (!busy_r && sel_valid_s) begin
            trmt_r    <= 1'b1;
            tx_data_r <= sel_data_s;
            req_ack_r <= grant_r;
            busy_r    <= 1'b1;
            cnt_r     <= 16'd0;
            if (sel_last_s) begin
              state_r <= DRAIN;
            end
          end else if (!busy_r) begin
            if (cnt_r == TO_LAST) begin
              abort_r <= 1'b1;
              grant_r <= '0;
              ptr_r   <= next_ptr_s;
              cnt_r   <= 16'd0;
              state_r <= IDLE;
            end else begin
              cnt_r <= cnt_r + 16'd1;
            end
          end
        end
        DRAIN: begin
          if (!busy_r) begin
            grant_r <= '0;
            ptr_r   <= next_ptr_s;
            state_r <= IDLE;
          end
        end
        default: begin
          grant_r <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign req_ack = req_ack_r;
  assign grant   = grant_r;
  assign abort   = abort_r;
  assign trmt    = trmt_r;
  assign tx_data = tx_data_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a simple UART_tx timing model and a
// trmt logger; expected bytes, grants and cycle offsets are hand-derived.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ack;
  logic [1:0]  grant;
  logic        abort;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ucnt     = 0;
  int byte_time = 5208;
  int ack_lim   = 6000;
  int raise_cyc = 0;

  logic [7:0] log_data[$];
  logic [1:0] log_grant[$];
  int         log_cyc[$];

  logic [7:0] exp_d[8];
  logic [1:0] exp_g[8];
  int         exp_n;

  uart_tx_arb #(.NUM_REQ(2), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ack   (req_ack),
    .grant     (grant),
    .abort     (abort),
    .trmt      (trmt),
    .tx_data   (tx_data),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART_tx model: trmt clears tx_done, which rises byte_time edges later.
  always @(posedge clk) begin
    if (trmt) begin
      tx_done <= 1'b0;
      ucnt    <= byte_time;
    end else if (ucnt > 0) begin
      ucnt <= ucnt - 1;
      if (ucnt == 1) tx_done <= 1'b1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Log every trmt and require req_ack to coincide with it on the granted bit.
  always @(negedge clk) begin
    if (trmt) begin
      log_data.push_back(tx_data);
      log_grant.push_back(grant);
      log_cyc.push_back(cyc);
    end
    if (trmt || (req_ack != 2'b00))
      check_val("ack_trmt", 32'(req_ack), 32'(trmt ? grant : 2'b00));
  end

  task automatic present_byte(input int r, input logic [7:0] d, input logic l);
    logic got;
    got = 1'b0;
    @(negedge clk);
    req_valid[r] = 1'b1;
    req_data[r*8 +: 8] = d;
    req_last[r] = l;
    raise_cyc = cyc;
    for (int k = 0; k < ack_lim && !got; k++) begin
      @(posedge clk);
      #1;
      got = req_ack[r];
    end
    check_val("ack_seen", 32'(got), 32'd1);
  endtask

  task automatic send_pkt(input int r, input int n, input logic [63:0] bytes, input logic l);
    for (int k = 0; k < n; k++)
      present_byte(r, bytes[8*k +: 8], l && (k == n - 1));
    @(negedge clk);
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic wait_grant(input logic [1:0] g, input int lim, input string tag, output int at);
    logic ok;
    ok = 1'b0;
    at = -1;
    for (int k = 0; k < lim && !ok; k++) begin
      @(negedge clk);
      ok = (grant == g);
      if (ok) at = cyc;
    end
    check_val(tag, 32'(ok), 32'd1);
  endtask

  // sel 0 watches tx_done, sel 1 watches abort.
  task automatic wait_bit(input int sel, input logic v, input int lim, input string tag, output int at);
    logic ok;
    ok = 1'b0;
    at = -1;
    for (int k = 0; k < lim && !ok; k++) begin
      @(negedge clk);
      ok = (((sel == 0) ? tx_done : abort) == v);
      if (ok) at = cyc;
    end
    check_val(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_log(input string tag, input int base);
    check_val({tag, "_count"}, 32'(log_data.size() - base), 32'(exp_n));
    for (int k = 0; k < exp_n; k++) begin
      if (base + k < log_data.size()) begin
        check_val({tag, "_data"}, 32'(log_data[base+k]), 32'(exp_d[k]));
        check_val({tag, "_grant"}, 32'(log_grant[base+k]), 32'(exp_g[k]));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t0, t1, r_first, at;
    req_valid = 2'b00;
    req_last  = 2'b00;
    req_data  = 16'h0000;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_trmt", 32'(trmt), 32'd0);
    check_val("rst_tx_data", 32'(tx_data), 32'd0);
    check_val("rst_req_ack", 32'(req_ack), 32'd0);
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_abort", 32'(abort), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_grant", 32'(grant), 32'd0);

    // Single 8-byte packet from requester 0 at 5208 cycles per byte.
    exp_d = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    exp_n = 8;
    base = log_data.size();
    r_first = 0;
    for (int k = 0; k < 8; k++) begin
      present_byte(0, exp_d[k], k == 7);
      if (k == 0) r_first = raise_cyc;
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_last[0]  = 1'b0;
    wait_grant(2'b00, 6000, "t1_drain", at);
    check_log("t1", base);
    if (log_data.size() >= base + 8) begin
      check_val("t1_latency", 32'(log_cyc[base] - r_first), 32'd2);
      for (int k = 1; k < 8; k++)
        check_val("t1_spacing", 32'(log_cyc[base+k] - log_cyc[base+k-1]), 32'd5211);
    end

    // Contention from reset release: requester 0 packet first, then requester 1.
    byte_time = 20;
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_data  = {8'hE1, 8'h11};
    req_last  = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    base = log_data.size();
    fork
      send_pkt(0, 3, 64'h131211, 1'b1);
      send_pkt(1, 2, 64'hE2E1, 1'b1);
    join
    wait_grant(2'b00, 200, "t2_drain", at);
    exp_d = '{8'h11, 8'h12, 8'h13, 8'hE1, 8'hE2, 8'h00, 8'h00, 8'h00};
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    exp_n = 5;
    check_log("t2", base);

    // Fairness with back-to-back single-byte packets.
    base = log_data.size();
    fork
      begin
        for (int k = 0; k < 3; k++) send_pkt(0, 1, 64'(8'hA0 + k), 1'b1);
      end
      begin
        for (int j = 0; j < 3; j++) send_pkt(1, 1, 64'(8'hB0 + j), 1'b1);
      end
    join
    wait_grant(2'b00, 200, "t3_drain", at);
    exp_d = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'h00, 8'h00};
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    exp_n = 6;
    check_log("t3", base);

    // Timeout: open packet abandoned by requester 0 while requester 1 waits.
    base = log_data.size();
    present_byte(0, 8'hAA, 1'b0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    fork
      present_byte(1, 8'hC1, 1'b1);
      begin
        wait_bit(0, 1'b0, 100, "t4_txd_lo", t0);
        wait_bit(0, 1'b1, 100, "t4_txd_hi", t0);
        wait_bit(1, 1'b1, 100, "t4_abort", t1);
        check_val("t4_abort_delay", 32'(t1 - t0), 32'd17);
        check_val("t4_grant_clr", 32'(grant), 32'd0);
        @(negedge clk);
        check_val("t4_abort_pulse", 32'(abort), 32'd0);
        wait_grant(2'b10, 100, "t4_regrant", at);
      end
    join
    @(negedge clk);
    req_valid[1] = 1'b0;
    req_last[1]  = 1'b0;
    wait_grant(2'b00, 100, "t4_drain", at);
    exp_d = '{8'hAA, 8'hC1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_g = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    exp_n = 2;
    check_log("t4", base);

    // Reset in the middle of a 5-byte packet, then a clean packet from requester 1.
    present_byte(0, 8'hB1, 1'b0);
    present_byte(0, 8'hB2, 1'b0);
    rst_n = 1'b0;
    #1;
    check_val("t5_trmt", 32'(trmt), 32'd0);
    check_val("t5_tx_data", 32'(tx_data), 32'd0);
    check_val("t5_req_ack", 32'(req_ack), 32'd0);
    check_val("t5_grant", 32'(grant), 32'd0);
    check_val("t5_abort", 32'(abort), 32'd0);
    req_valid = 2'b00;
    req_last  = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    base = log_data.size();
    present_byte(1, 8'hD1, 1'b0);
    r_first = raise_cyc;
    present_byte(1, 8'hD2, 1'b1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    req_last[1]  = 1'b0;
    wait_grant(2'b00, 200, "t5_drain", at);
    exp_d = '{8'hD1, 8'hD2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_g = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    exp_n = 2;
    check_log("t5", base);
    if (log_data.size() > base)
      check_val("t5_latency", 32'(log_cyc[base] - r_first), 32'd2);

    // Single-byte packet issued while tx_done is still high from the last byte.
    check_val("t6_txd_pre", 32'(tx_done), 32'd1);
    base = log_data.size();
    present_byte(0, 8'h5A, 1'b1);
    r_first = raise_cyc;
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_last[0]  = 1'b0;
    wait_grant(2'b00, 100, "t6_drain", at);
    repeat (30) @(negedge clk);
    exp_d = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_g = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    exp_n = 1;
    check_log("t6", base);
    if (log_data.size() > base) begin
      check_val("t6_latency", 32'(log_cyc[base] - r_first), 32'd2);
      check_val("t6_drain_time", 32'(at - log_cyc[base]), 32'd23);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
